div_seq_unit: RTL

- Multi-cycle unsigned radix-2 restoring divider.
- Acts as the responder side of the valid/done handshake that the execute stage drives for DIV/DIVU.
- Execute does all sign correction. It holds the operands and valid high while stalling (stall = valid & ~done), then consumes {remainder, quotient} in the cycle done is high.

---
 rtl/div_seq_unit_if.sv | 14 +
 rtl/div_seq_unit.sv | 105 ++++++++++
 2 files changed

// File: rtl/div_seq_unit_if.sv
// Valid/done handshake bundle between the execute stage (master) and the divider (slave).
`timescale 1ns/1ps
interface div_seq_unit_if #(
  parameter int WIDTH = 32
);
  logic               valid;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               done;
  logic [2*WIDTH-1:0] c;

  modport master (output valid, output a, output b, input done, input c);
  modport slave  (input valid, input a, input b, output done, output c);
endinterface

// File: rtl/div_seq_unit.sv
// Multi-cycle unsigned radix-2 restoring divider; c = {remainder, quotient}.
// Define DIV_SEQ_EARLY_EN to finish a<b and b==0 requests in two cycles.
`timescale 1ns/1ps
module div_seq_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic          clk,
  input  logic          resetn,
  div_seq_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   rem_acc;
  logic [WIDTH-1:0]   quo_acc;
  logic [2*WIDTH-1:0] c_q;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   rem_step;
  logic [WIDTH-1:0]   quo_step;
  logic               last_step;
  logic               early;

  // rem_acc keeps only W bits: the top bit of the W+1-bit accumulator is
  // always zero between steps because the remainder stays below b.
  always_comb begin
    rem_sh    = {rem_acc, quo_acc[WIDTH-1]};
    trial     = rem_sh - {1'b0, b_q};
    if (!trial[WIDTH]) begin
      rem_step = trial[WIDTH-1:0];
      quo_step = {quo_acc[WIDTH-2:0], 1'b1};
    end else begin
      rem_step = rem_sh[WIDTH-1:0];
      quo_step = {quo_acc[WIDTH-2:0], 1'b0};
    end
    last_step = (cnt == CNT_W'(1));
`ifdef DIV_SEQ_EARLY_EN
    early = (bus.a < bus.b) || (bus.b == '0);
`else
    early = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.valid) state_nxt = early ? DONE : BUSY;
      BUSY: begin
        if (!bus.valid)     state_nxt = IDLE;
        else if (last_step) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt     <= '0;
      b_q     <= '0;
      rem_acc <= '0;
      quo_acc <= '0;
      c_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.valid) begin
            b_q     <= bus.b;
            rem_acc <= '0;
            quo_acc <= bus.a;
            cnt     <= CNT_W'(WIDTH);
`ifdef DIV_SEQ_EARLY_EN
            if (bus.b == '0)
              c_q <= {bus.a, {WIDTH{1'b1}}};
            else if (bus.a < bus.b)
              c_q <= {bus.a, {WIDTH{1'b0}}};
`endif
          end
        end
        BUSY: begin
          if (bus.valid) begin
            rem_acc <= rem_step;
            quo_acc <= quo_step;
            cnt     <= cnt - CNT_W'(1);
            if (last_step) c_q <= {rem_step, quo_step};
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.done = (state == DONE);
  assign bus.c    = c_q;

endmodule
